// File: rtl/tube_pkg.sv
// Shared constants, FSM state type and write payload for the tube write arbiter.
package tube_pkg;

  localparam int unsigned TUBE_ADDR_W = 3;
  localparam int unsigned TUBE_DATA_W = 16;

  localparam logic [TUBE_ADDR_W-1:0] TUBE_ADDR_LOW     = 3'b000;
  localparam logic [TUBE_ADDR_W-1:0] TUBE_ADDR_HIGH    = 3'b010;
  localparam logic [TUBE_ADDR_W-1:0] TUBE_ADDR_SPECIAL = 3'b100;

  // Half of the tube's internal refresh period, in system clocks.
  localparam int unsigned TUBE_REFRESH_HALF = 26;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_HOLD = 2'd1,
    ARB_GAP  = 2'd2,
    ARB_REJ  = 2'd3
  } arb_state_e;

  typedef struct packed {
    logic [TUBE_ADDR_W-1:0] addr;
    logic [TUBE_DATA_W-1:0] data;
  } tube_wr_t;

  function automatic logic tube_addr_legal(input logic [TUBE_ADDR_W-1:0] addr);
    return (addr == TUBE_ADDR_LOW) || (addr == TUBE_ADDR_HIGH) ||
           (addr == TUBE_ADDR_SPECIAL);
  endfunction

endpackage

// File: rtl/tube_req_picker.sv
// Combinational one-hot requester selection.
// TUBE_ARB_ROUND_ROBIN_EN: search starts at rr_ptr; otherwise lowest index wins.
module tube_req_picker #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned IDX_W = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [N_REQ-1:0] winner,
  output logic             valid
);

  assign valid = |req;

`ifdef TUBE_ARB_ROUND_ROBIN_EN
  logic [2*N_REQ-1:0] req2;
  logic [2*N_REQ-1:0] win2;
  logic [N_REQ-1:0]   rot;
  logic [N_REQ-1:0]   first;

  // Rotate so rr_ptr sits at bit 0, take the lowest set bit, rotate back.
  always_comb begin
    req2   = {req, req};
    rot    = N_REQ'(req2 >> rr_ptr);
    first  = rot & (~rot + N_REQ'(1));
    win2   = {{N_REQ{1'b0}}, first} << rr_ptr;
    winner = win2[N_REQ-1:0] | win2[2*N_REQ-1:N_REQ];
  end
`else
  logic unused_rr_ptr;
  assign unused_rr_ptr = ^rr_ptr;
  assign winner = req & (~req + N_REQ'(1));
`endif

endmodule

// File: rtl/tube_write_arbiter.sv
// Shares the 7-segment tube write port among N_REQ requesters, holding each write
// stable across the tube refresh edge. Option macro: TUBE_ARB_ROUND_ROBIN_EN.
module tube_write_arbiter
  import tube_pkg::*;
#(
  parameter int unsigned N_REQ       = 2,
  parameter int unsigned HOLD_CYCLES = 64,
  parameter int unsigned GAP_CYCLES  = 8,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [N_REQ-1:0]             req,
  input  logic [TUBE_ADDR_W*N_REQ-1:0] req_addr,
  input  logic [TUBE_DATA_W*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]             grant,
  output logic [N_REQ-1:0]             done,
  output logic                         err,
  output logic                         busy,
  output logic                         tube_we,
  output logic                         tube_ctrl,
  output logic [TUBE_ADDR_W-1:0]       tube_addr,
  output logic [TUBE_DATA_W-1:0]       tube_data
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic [N_REQ-1:0] win_q, win_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             tube_we_q, tube_we_d;
  logic             tube_ctrl_q;
  tube_wr_t         wr_q, wr_d;

  logic [N_REQ-1:0] req_eff;
  logic [N_REQ-1:0] pick_win;
  logic             pick_valid;
  logic [IDX_W-1:0] rr_ptr;
  tube_wr_t         sel_wr;

  // The requester just completed is ignored on its done cycle so a req not yet
  // dropped is not mistaken for a new one.
  assign req_eff = req & ~done_q;

  tube_req_picker #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req    (req_eff),
    .rr_ptr (rr_ptr),
    .winner (pick_win),
    .valid  (pick_valid)
  );

  always_comb begin
    sel_wr = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (pick_win[i]) begin
        sel_wr.addr = req_addr[TUBE_ADDR_W*i +: TUBE_ADDR_W];
        sel_wr.data = req_data[TUBE_DATA_W*i +: TUBE_DATA_W];
      end
    end
  end

`ifdef TUBE_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d, rr_next;

  always_comb begin
    rr_next = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (pick_win[i]) rr_next = IDX_W'((i + 1) % N_REQ);
    end
    rr_ptr_d = ((state_q == ARB_IDLE) && pick_valid) ? rr_next : rr_ptr_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) rr_ptr_q <= '0;
    else       rr_ptr_q <= rr_ptr_d;
  end

  assign rr_ptr = rr_ptr_q;
`else
  assign rr_ptr = '0;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    grant_d   = '0;
    done_d    = '0;
    err_d     = 1'b0;
    win_d     = win_q;
    tube_we_d = tube_we_q;
    wr_d      = wr_q;

    case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          grant_d = pick_win;
          win_d   = pick_win;
          wr_d    = sel_wr;
          if (tube_addr_legal(sel_wr.addr)) begin
            state_d   = ARB_HOLD;
            cnt_d     = CNT_W'(HOLD_CYCLES - 1);
            tube_we_d = 1'b1;
          end else begin
            state_d = ARB_REJ;
          end
        end
      end
      ARB_HOLD: begin
        if (cnt_q == '0) begin
          done_d    = win_q;
          tube_we_d = 1'b0;
          cnt_d     = CNT_W'(GAP_CYCLES - 1);
          state_d   = ARB_GAP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ARB_GAP: begin
        if (cnt_q == '0) state_d = ARB_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ARB_REJ: begin
        done_d  = win_q;
        err_d   = 1'b1;
        state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase

    busy_d = (state_d != ARB_IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ARB_IDLE;
      cnt_q       <= '0;
      grant_q     <= '0;
      done_q      <= '0;
      err_q       <= 1'b0;
      win_q       <= '0;
      busy_q      <= 1'b0;
      tube_we_q   <= 1'b0;
      tube_ctrl_q <= 1'b0;
      wr_q        <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      err_q       <= err_d;
      win_q       <= win_d;
      busy_q      <= busy_d;
      tube_we_q   <= tube_we_d;
      tube_ctrl_q <= 1'b1;
      wr_q        <= wr_d;
    end
  end

  assign grant     = grant_q;
  assign done      = done_q;
  assign err       = err_q;
  assign busy      = busy_q;
  assign tube_we   = tube_we_q;
  assign tube_ctrl = tube_ctrl_q;
  assign tube_addr = wr_q.addr;
  assign tube_data = wr_q.data;

endmodule

// File: tb/tb_tube_write_arbiter.sv
// Self-checking bench for tube_write_arbiter: directed scenarios then random traffic,
// compared every cycle against a cycle-count reference model.
module tb_tube_write_arbiter;

  localparam int N_REQ = 2;
  localparam int HOLD  = 64;
  localparam int GAP   = 8;

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic                 r [N_REQ];
  logic [2:0]           a [N_REQ];
  logic [15:0]          d [N_REQ];
  logic [N_REQ-1:0]     req;
  logic [3*N_REQ-1:0]   req_addr;
  logic [16*N_REQ-1:0]  req_data;
  logic [N_REQ-1:0]     grant, done;
  logic                 err, busy, tube_we, tube_ctrl;
  logic [2:0]           tube_addr;
  logic [15:0]          tube_data;

  int total = 0;
  int bad   = 0;
  int n     = 0;
  bit hold_mode = 1'b0;
  bit rand_en   = 1'b0;

  // Reference model: cycle numbers of the events of the current write.
  int m_g, m_w, m_done_at, m_err_at, m_we_lo, m_we_hi, m_busy_hi;
  int m_next_dec, m_mask_at, m_mask_w, m_rr;
  int m_ctrl_from = 1 << 30;
  logic [2:0]  m_addr;
  logic [15:0] m_data;

  always #5 clock = ~clock;

  always_comb begin
    req      = '0;
    req_addr = '0;
    req_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req[i]              = r[i];
      req_addr[3*i +: 3]  = a[i];
      req_data[16*i +: 16] = d[i];
    end
  end

  tube_write_arbiter dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .grant     (grant),
    .done      (done),
    .err       (err),
    .busy      (busy),
    .tube_we   (tube_we),
    .tube_ctrl (tube_ctrl),
    .tube_addr (tube_addr),
    .tube_data (tube_data)
  );

  function automatic logic [N_REQ-1:0] onehot(input int w);
    return N_REQ'(1) << w;
  endfunction

  function automatic logic bit_of(input logic [N_REQ-1:0] v, input int j);
    logic [N_REQ-1:0] t;
    t = v >> j;
    return t[0];
  endfunction

  function automatic logic legal(input logic [2:0] x);
    return (x == 3'd0) || (x == 3'd2) || (x == 3'd4);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, n, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_g = -1000; m_w = 0; m_done_at = -1000; m_err_at = -1000;
    m_we_lo = -1000; m_we_hi = -2000; m_busy_hi = -2000;
    m_mask_at = -1000; m_mask_w = 0; m_rr = 0;
    m_addr = '0; m_data = '0;
  endtask

  task automatic model_step();
    int w;
    if (reset) begin
      model_clear();
      m_ctrl_from = n + 1;
      m_next_dec  = n + 1;
      return;
    end
    if (n < m_next_dec) return;
    w = -1;
`ifdef TUBE_ARB_ROUND_ROBIN_EN
    for (int k = 0; k < N_REQ; k++) begin
      int j;
      j = (m_rr + k) % N_REQ;
      if (w < 0 && r[j] && !(n == m_mask_at && j == m_mask_w)) w = j;
    end
`else
    for (int j = 0; j < N_REQ; j++)
      if (w < 0 && r[j] && !(n == m_mask_at && j == m_mask_w)) w = j;
`endif
    if (w < 0) return;
    m_g = n; m_w = w; m_addr = a[w]; m_data = d[w];
    m_rr = (w + 1) % N_REQ;
    if (legal(m_addr)) begin
      m_we_lo = n; m_we_hi = n + HOLD - 1; m_done_at = n + HOLD; m_err_at = -1000;
      m_busy_hi = n + HOLD + GAP - 1; m_next_dec = n + HOLD + GAP + 1;
    end else begin
      m_we_lo = -1000; m_we_hi = -2000; m_done_at = n + 1; m_err_at = n + 1;
      m_busy_hi = n; m_next_dec = n + 2; m_mask_at = n + 2; m_mask_w = w;
    end
  endtask

  task automatic check_outputs();
    logic [N_REQ-1:0] eg, ed;
    eg = (n == m_g) ? onehot(m_w) : '0;
    ed = (n == m_done_at) ? onehot(m_w) : '0;
    chk("grant", 32'(grant), 32'(eg));
    chk("done", 32'(done), 32'(ed));
    chk("err", 32'(err), 32'(n == m_err_at));
    chk("busy", 32'(busy), 32'(n >= m_g && n <= m_busy_hi));
    chk("tube_we", 32'(tube_we), 32'(n >= m_we_lo && n <= m_we_hi));
    chk("tube_ctrl", 32'(tube_ctrl), 32'(!reset && n >= m_ctrl_from));
    chk("tube_addr", 32'(tube_addr), 32'(m_addr));
    chk("tube_data", 32'(tube_data), 32'(m_data));
  endtask

  // Requesters drop req on their grant; in random mode they also raise/withdraw.
  task automatic drive_requesters();
    for (int i = 0; i < N_REQ; i++) begin
      if (m_g == n && m_w == i) begin
        if (!hold_mode) begin
          r[i] = 1'b0;
          if (rand_en) d[i] = 16'($urandom);
        end
      end else if (rand_en) begin
        if (!r[i]) begin
          if ($urandom_range(0, 15) == 0) begin
            r[i] = 1'b1;
            if ($urandom_range(0, 3) == 0) a[i] = 3'($urandom);
            else a[i] = 3'($urandom_range(0, 2) * 2);
            d[i] = 16'($urandom);
          end
        end else if ($urandom_range(0, 299) == 0) begin
          r[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    n++;
    model_step();
    #1;
    check_outputs();
    drive_requesters();
  endtask

  task automatic wait_grant(input string tag, input int idx, input int budget, output int at);
    at = -1;
    for (int k = 0; k < budget && at < 0; k++) begin
      cycle();
      if (bit_of(grant, idx)) at = n;
    end
    chk({tag, "_seen"}, 32'(at >= 0), 32'd1);
  endtask

  task automatic wait_done(input string tag, input int idx, input int budget, output int at);
    at = -1;
    for (int k = 0; k < budget && at < 0; k++) begin
      cycle();
      if (bit_of(done, idx)) at = n;
    end
    chk({tag, "_seen"}, 32'(at >= 0), 32'd1);
  endtask

  initial begin
    int g0, g1, dn, we_cnt;
    int order [$];
    for (int i = 0; i < N_REQ; i++) begin
      r[i] = 1'b0; a[i] = '0; d[i] = '0;
    end
    model_clear();
    m_next_dec = 0;

    // Reset state
    repeat (3) cycle();
    chk("rst_ctrl", 32'(tube_ctrl), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    cycle();
    chk("post_rst_ctrl", 32'(tube_ctrl), 32'd1);

    // Single legal write, then data changed after grant
    a[0] = 3'b000; d[0] = 16'h1234; r[0] = 1'b1;
    wait_grant("t1_grant", 0, 5, g0);
    chk("t1_grant_lat", 32'(g0 - n), 32'd0);
    d[0] = 16'hBEEF;
    we_cnt = 32'(tube_we);
    dn = -1;
    for (int k = 0; k < 100 && dn < 0; k++) begin
      cycle();
      if (tube_we) begin
        we_cnt++;
        chk("t6_data_held", 32'(tube_data), 32'h1234);
      end
      if (done[0]) dn = n;
    end
    chk("t1_we_count", 32'(we_cnt), 32'd64);
    chk("t1_done_lat", 32'(dn - g0), 32'd64);
    repeat (10) cycle();

    // Illegal address on requester 1
    a[1] = 3'b001; d[1] = 16'h0F0F; r[1] = 1'b1;
    wait_grant("t3_grant", 1, 5, g1);
    chk("t3_we_at_grant", 32'(tube_we), 32'd0);
    cycle();
    chk("t3_done", 32'(done), 32'b10);
    chk("t3_err", 32'(err), 32'd1);
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("t3_no_we", 32'(tube_we), 32'd0);
    end

    // Contention, both requests held
    hold_mode = 1'b1;
    a[0] = 3'b010; d[0] = 16'hAAAA; r[0] = 1'b1;
    a[1] = 3'b100; d[1] = 16'h5555; r[1] = 1'b1;
    for (int k = 0; k < 400 && order.size() < 4; k++) begin
      cycle();
      for (int i = 0; i < N_REQ; i++) if (bit_of(grant, i)) order.push_back(i);
    end
    chk("t2_grants", 32'(order.size()), 32'd4);
    foreach (order[k]) begin
`ifdef TUBE_ARB_ROUND_ROBIN_EN
      chk("t2_order", 32'(order[k]), 32'(k % 2));
`else
      chk("t2_order", 32'(order[k]), 32'd0);
`endif
    end
    hold_mode = 1'b0;
    r[0] = 1'b0; r[1] = 1'b0;
    repeat (80) cycle();

    // Back-to-back: requester 1 arrives during requester 0's hold
    a[0] = 3'b000; d[0] = 16'h1111; r[0] = 1'b1;
    wait_grant("t4_grant0", 0, 5, g0);
    repeat (10) cycle();
    a[1] = 3'b010; d[1] = 16'h2222; r[1] = 1'b1;
    wait_grant("t4_grant1", 1, 100, g1);
    chk("t4_spacing", 32'(g1 - g0), 32'd73);
    repeat (80) cycle();

    // Asynchronous reset in the middle of a hold
    a[0] = 3'b100; d[0] = 16'h5A5A; r[0] = 1'b1;
    wait_grant("t5_grant", 0, 5, g0);
    repeat (20) cycle();
    chk("t5_we_before", 32'(tube_we), 32'd1);
    #3 reset = 1'b1;
    #1;
    model_clear();
    m_ctrl_from = 1 << 30;
    chk("t5_we_rst", 32'(tube_we), 32'd0);
    chk("t5_ctrl_rst", 32'(tube_ctrl), 32'd0);
    chk("t5_busy_rst", 32'(busy), 32'd0);
    repeat (3) cycle();
    reset = 1'b0;
    a[0] = 3'b010; d[0] = 16'hC0DE; r[0] = 1'b1;
    wait_grant("t5_regrant", 0, 5, g0);
    wait_done("t5_done", 0, 100, dn);
    chk("t5_done_lat", 32'(dn - g0), 32'd64);
    repeat (10) cycle();

    // Random traffic
    rand_en = 1'b1;
    repeat (3000) cycle();
    rand_en = 1'b0;
    for (int i = 0; i < N_REQ; i++) r[i] = 1'b0;
    repeat (90) cycle();
    chk("final_idle", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
